// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus master and slave ports.
package bus_pkg;

  // Port transaction phases.
  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAddr,
    StWdata,
    StRdata,
    StDone
  } port_state_e;

  // Transaction mode as carried on mmode.
  localparam logic ModeRead  = 1'b0;
  localparam logic ModeWrite = 1'b1;

  function automatic int unsigned max_uint(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/master_port.sv
// Device-side request port that arbitrates for the serial bus, shifts out
// address and write data LSB first, and assembles serial read data with a
// timeout on a silent slave.
module master_port
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  // Device side
  input  logic                  dvalid,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dready,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  ddone,
  output logic                  derr,
  // Bus side
  output logic                  mbreq,
  input  logic                  mbgrant,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  mrdata,
  input  logic                  svalid,
  input  logic                  sready
);

  localparam int unsigned CntMax = max_uint(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned WaitW  = $clog2(TIMEOUT + 1);

  port_state_e           state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WaitW-1:0]      wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] rbuf_q, rbuf_d;
  logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] rbuf_next;
  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0] wdata_sh;

  // Next-state: phase sequencing, bit/timeout counting and read assembly.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mode_d    = mode_q;
    rbuf_d    = rbuf_q;
    drdata_d  = drdata_q;
    err_d     = err_q;
    rbuf_next = rbuf_q | (DATA_WIDTH'(mrdata) << cnt_q);

    unique case (state_q)
      StIdle: begin
        if (dvalid) begin
          addr_d  = daddr;
          wdata_d = dwdata;
          mode_d  = dmode;
          cnt_d   = '0;
          wait_d  = '0;
          rbuf_d  = '0;
          err_d   = 1'b0;
          state_d = StReq;
        end
      end
      StReq: begin
        // Grant is only sampled here; the arbiter holds it while mbreq is high.
        if (mbgrant && sready) begin
          cnt_d   = '0;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (cnt_q == CntW'(ADDR_WIDTH - 1)) begin
          cnt_d   = '0;
          wait_d  = '0;
          state_d = (mode_q == ModeWrite) ? StWdata : StRdata;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWdata: begin
        if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRdata: begin
        if (svalid) begin
          rbuf_d = rbuf_next;
          wait_d = '0;
          if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
            drdata_d = rbuf_next;
            cnt_d    = '0;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
          // Silent slave: finish with an error and keep the old read data.
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      wait_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mode_q   <= 1'b0;
      rbuf_q   <= '0;
      drdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mode_q   <= mode_d;
      rbuf_q   <= rbuf_d;
      drdata_q <= drdata_d;
      err_q    <= err_d;
    end
  end

  // Outputs decoded from registered state only; no input reaches them.
  always_comb begin
    addr_sh  = addr_q >> cnt_q;
    wdata_sh = wdata_q >> cnt_q;
    dready   = 1'b0;
    mbreq    = 1'b0;
    mvalid   = 1'b0;
    mwdata   = 1'b0;
    mmode    = 1'b0;
    unique case (state_q)
      StIdle: dready = 1'b1;
      StReq:  mbreq  = 1'b1;
      StAddr: begin
        mbreq  = 1'b1;
        mvalid = 1'b1;
        mwdata = addr_sh[0];
        mmode  = mode_q;
      end
      StWdata: begin
        mbreq  = 1'b1;
        mvalid = 1'b1;
        mwdata = wdata_sh[0];
        mmode  = mode_q;
      end
      StRdata: begin
        mbreq = 1'b1;
        mmode = mode_q;
      end
      default: ;
    endcase
  end

  assign drdata = drdata_q;
  assign ddone  = (state_q == StDone);
  assign derr   = err_q;

endmodule

// File: tb/tb_master_port.sv
// Scoreboard bench for master_port: expected serial bits and completion
// results are queued when a request is issued and checked as the port emits them.
module tb_master_port;
  import bus_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          dvalid, dmode;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic          dready;
  logic [DW-1:0] drdata;
  logic          ddone, derr;
  logic          mbreq, mbgrant, mwdata, mmode, mvalid;
  logic          mrdata, svalid, sready;

  master_port #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (16)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .dvalid (dvalid),
    .dmode  (dmode),
    .daddr  (daddr),
    .dwdata (dwdata),
    .dready (dready),
    .drdata (drdata),
    .ddone  (ddone),
    .derr   (derr),
    .mbreq  (mbreq),
    .mbgrant(mbgrant),
    .mwdata (mwdata),
    .mmode  (mmode),
    .mvalid (mvalid),
    .mrdata (mrdata),
    .svalid (svalid),
    .sready (sready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic m;
  } bit_t;

  typedef struct packed {
    logic [DW-1:0] rd;
    logic          err;
    logic          wr;
    logic [7:0]    nbits;
  } res_t;

  bit_t exp_bits[$];
  res_t res_q[$];
  logic [DW-1:0] last_rd;

  int n_checks = 0;
  int n_errors = 0;
  int mv_cnt = 0;
  logic prev_mv = 1'b0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bus/completion monitor, sampling on the falling edge.
  always @(negedge clk) begin
    bit_t bx;
    res_t rx;
    if (!rstn) begin
      mv_cnt  = 0;
      prev_mv = 1'b0;
    end else if (mon_en) begin
      if (mvalid === 1'b1) begin
        check("mbreq_busy", mbreq, 1);
        if (exp_bits.size() == 0) begin
          check("extra_bit", 1, 0);
        end else begin
          bx = exp_bits.pop_front();
          check("mwdata", mwdata, bx.b);
          check("mmode", mmode, bx.m);
        end
        mv_cnt++;
      end else begin
        check("mwdata_quiet", mwdata, 0);
      end
      if (ddone === 1'b1) begin
        if (res_q.size() == 0) begin
          check("ddone_unexpected", 1, 0);
        end else begin
          rx = res_q.pop_front();
          check("drdata", drdata, rx.rd);
          check("derr", derr, rx.err);
          check("mvalid_cycles", mv_cnt, rx.nbits);
          check("mbreq_done", mbreq, 0);
          check("mmode_done", mmode, 0);
          if (rx.wr) check("ddone_after_wdata", prev_mv, 1);
        end
        mv_cnt = 0;
      end
      prev_mv = mvalid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for dready, present one request, queue its expectations.
  task automatic issue(input logic mode, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic tmo);
    res_t r;
    int k;
    k = 0;
    while (dready !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    check("dready_wait", dready, 1);
    for (int i = 0; i < int'(AW); i++) exp_bits.push_back('{b: a[i], m: mode});
    if (mode == ModeWrite) begin
      for (int i = 0; i < int'(DW); i++) exp_bits.push_back('{b: d[i], m: mode});
      r = '{rd: last_rd, err: 1'b0, wr: 1'b1, nbits: 8'(AW + DW)};
    end else begin
      if (!tmo) last_rd = d;
      r = '{rd: last_rd, err: tmo, wr: 1'b0, nbits: 8'(AW)};
    end
    res_q.push_back(r);
    dvalid = 1'b1;
    dmode  = mode;
    daddr  = a;
    dwdata = d;
    step();
    dvalid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (ddone !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    check("ddone_seen", ddone, 1);
  endtask

  // Return to the first RDATA cycle (first idle mvalid after the address).
  task automatic wait_addr_end();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (mvalid === 1'b1) seen = 1'b1;
      else if (seen) break;
      step();
    end
    check("addr_phase_end", seen && (mvalid === 1'b0), 1);
  endtask

  // Slave model: serve one read word with idle gaps between bits.
  task automatic serve_read(input logic [DW-1:0] d);
    int gap;
    wait_addr_end();
    for (int i = 0; i < int'(DW); i++) begin
      gap = (i == 0) ? 15 : (i % 3);
      svalid = 1'b0;
      repeat (gap) step();
      svalid = 1'b1;
      mrdata = d[i];
      step();
      svalid = 1'b0;
      mrdata = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dready"}, dready, 1);
    check({tag, "_ddone"}, ddone, 0);
    check({tag, "_derr"}, derr, 0);
    check({tag, "_drdata"}, drdata, 0);
    check({tag, "_mbreq"}, mbreq, 0);
    check({tag, "_mvalid"}, mvalid, 0);
    check({tag, "_mwdata"}, mwdata, 0);
    check({tag, "_mmode"}, mmode, 0);
  endtask

  initial begin
    int n;
    rstn    = 1'b0;
    dvalid  = 1'b0;
    dmode   = 1'b0;
    daddr   = '0;
    dwdata  = '0;
    mbgrant = 1'b1;
    sready  = 1'b1;
    svalid  = 1'b0;
    mrdata  = 1'b0;
    last_rd = '0;
    repeat (2) step();
    check_reset_outputs("reset");
    rstn   = 1'b1;
    mon_en = 1'b1;
    step();
    check("idle_dready", dready, 1);

    // Write 0xA5 to 0x3C7 with immediate grant.
    issue(ModeWrite, 12'h3C7, 8'hA5, 1'b0);
    wait_done();
    step();

    // Read 0x5A from 0x001 with gaps, including a 15-cycle gap just under timeout.
    issue(ModeRead, 12'h001, 8'h5A, 1'b0);
    serve_read(8'h5A);
    wait_done();
    step();

    // Read from a silent slave: error after 16 RDATA cycles, drdata kept.
    issue(ModeRead, 12'h2B4, 8'h00, 1'b1);
    wait_addr_end();
    n = 0;
    while (ddone !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("timeout_cycles", n, 16);
    step();

    // Grant withheld 5 cycles, then sready low 3 cycles.
    mbgrant = 1'b0;
    issue(ModeWrite, 12'h155, 8'h3C, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("req_mbreq", mbreq, 1);
      check("req_mvalid", mvalid, 0);
      if (i == 4) begin
        mbgrant = 1'b1;
        sready  = 1'b0;
      end
      if (i == 7) sready = 1'b1;
      step();
    end
    check("addr_start", mvalid, 1);
    wait_done();
    step();

    // Device inputs thrash mid-transaction; latched request must hold.
    issue(ModeWrite, 12'h5F3, 8'h2A, 1'b0);
    for (int i = 0; i < 10; i++) begin
      dvalid = 1'($urandom);
      dmode  = 1'($urandom);
      daddr  = AW'($urandom);
      dwdata = DW'($urandom);
      step();
    end
    dvalid = 1'b0;
    wait_done();
    step();

    // One-cycle reset in the middle of WDATA aborts silently.
    issue(ModeWrite, 12'h0F0, 8'h99, 1'b0);
    n = 0;
    for (int k = 0; k < 100 && n < 15; k++) begin
      step();
      if (mvalid === 1'b1) n++;
    end
    check("reached_wdata", n, 15);
    rstn = 1'b0;
    exp_bits.delete();
    res_q.delete();
    last_rd = '0;
    step();
    check_reset_outputs("midreset");
    rstn = 1'b1;
    step();
    check("post_reset_dready", dready, 1);
    check("post_reset_ddone", ddone, 0);

    // Back-to-back: write, then a read accepted the cycle after DONE.
    issue(ModeWrite, 12'h800, 8'h7E, 1'b0);
    wait_done();
    step();
    check("b2b_dready", dready, 1);
    issue(ModeRead, 12'hFFF, 8'hC3, 1'b0);
    serve_read(8'hC3);
    wait_done();
    step();
    step();

    check("bits_drained", exp_bits.size(), 0);
    check("results_drained", res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/master_port.md
MASTER_PORT -- requirements
Module: master_port

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, serial address length in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, serial data length in bits.
REQ-003 SHALL have parameter TIMEOUT, default 16, max idle cycles waiting for read data.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 dvalid  in  1  device request strobe.
REQ-007 dmode  in  1  0 = read, 1 = write.
REQ-008 daddr  in  ADDR_WIDTH  target address.
REQ-009 dwdata  in  DATA_WIDTH  write data.
REQ-010 dready  out  1  high only in IDLE; port accepts a request.
REQ-011 drdata  out  DATA_WIDTH  last completed read data.
REQ-012 ddone  out  1  one-cycle pulse at transaction end.
REQ-013 derr  out  1  qualifies ddone; read timed out.
REQ-014 mbreq  out  1  bus request to arbiter.
REQ-015 mbgrant  in  1  bus grant from arbiter.
REQ-016 mwdata  out  1  serial address/write-data bit, LSB first.
REQ-017 mmode  out  1  transaction mode to slave.
REQ-018 mvalid  out  1  mwdata valid.
REQ-019 mrdata  in  1  serial read-data bit from slave.
REQ-020 svalid  in  1  mrdata valid.
REQ-021 sready  in  1  slave idle.

Function
REQ-022 States: IDLE, REQ, ADDR, WDATA, RDATA, DONE.
REQ-023 IDLE: dvalid=1 latches daddr/dwdata/dmode, clears bit counter, -> REQ; otherwise stay.
REQ-024 REQ: mbreq=1; -> ADDR on the first cycle with mbgrant=1 and sready=1.
REQ-025 ADDR: exactly ADDR_WIDTH consecutive cycles, mvalid=1, mwdata=addr[cnt] in cycle cnt (0..ADDR_WIDTH-1); then -> WDATA if write, else RDATA; counter cleared.
REQ-026 WDATA: exactly DATA_WIDTH consecutive cycles, mvalid=1, mwdata=wdata[cnt]; then -> DONE.
REQ-027 RDATA: mvalid=0; each cycle with svalid=1 stores mrdata into bit cnt and increments cnt; after bit DATA_WIDTH-1 -> DONE with drdata updated from the fully assembled word.
REQ-028 RDATA timeout: wait counter resets on every svalid=1 cycle; TIMEOUT consecutive cycles without svalid -> DONE with derr=1 and drdata unchanged.
REQ-029 DONE: one cycle; ddone=1; derr valid; mbreq=0; -> IDLE.
REQ-030 mmode SHALL equal the latched mode throughout ADDR, WDATA and RDATA, and SHALL be 0 otherwise.
REQ-031 mbreq SHALL be 1 from REQ through WDATA/RDATA, and 0 in IDLE and DONE.
REQ-032 mvalid and mwdata SHALL be 0 outside ADDR/WDATA.
REQ-033 Bus outputs SHALL be decoded from registered state/counter/latched data only; there SHALL be no combinational path from any input.
REQ-034 dvalid while dready=0 SHALL be ignored; latched request SHALL be immune to later device-input changes.
REQ-035 mbgrant deassertion after REQ SHALL be ignored (the arbiter holds grant while mbreq=1).
REQ-036 svalid outside RDATA SHALL be ignored.
REQ-037 Back-to-back: new request accepted in IDLE the cycle after DONE; REQ waits for sready, which covers the slave's post-write commit cycle.

Reset
REQ-038 rstn=0 at a clock edge: state=IDLE, counters=0, latched data=0, drdata=0, ddone=0, derr=0, mbreq=0, mvalid=0, mwdata=0, mmode=0.
REQ-039 Reset mid-transaction SHALL abort with no ddone pulse; dready=1 from the first cycle after rstn returns high.

Structure
REQ-040 State encoding and the bus mode constants (READ=0, WRITE=1) SHALL live in a shared package bus_pkg, used with the slave port.
REQ-041 No sub-module; the bit and timeout counters SHALL be inline, each sized $clog2 of its maximum count + 1.

Verification (ADDR_WIDTH=12, DATA_WIDTH=8)
REQ-042 Write 0xA5 to 0x3C7, grant immediate -> mvalid high 20 cycles, bits 1,1,1,0,0,0,1,1,1,1,0,0 then 1,0,1,0,0,1,0,1, mmode=1; ddone in the next cycle, derr=0.
REQ-043 Read from 0x001; slave model returns 0x5A with gaps in svalid -> drdata=0x5A at ddone, derr=0, mvalid=0 during RDATA.
REQ-044 Read where slave never asserts svalid -> ddone with derr=1 exactly 16 cycles after entering RDATA; drdata keeps its prior value.
REQ-045 Grant withheld 5 cycles, then sready low 3 more -> ADDR begins the first cycle both are high; mbreq held high throughout.
REQ-046 dvalid toggled and daddr changed during a transaction -> ignored; serialized address matches the originally latched value.
REQ-047 rstn low for one cycle in the middle of WDATA -> all outputs at reset values, no ddone, dready=1 the next cycle.
